el2_ifu_iccm_access_ctrl: RTL and testbench

EL2_IFU_ICCM_ACCESS_CTRL -- requirements
Module: el2_ifu_iccm_access_ctrl

---
 rtl/el2_pkg.sv | 46 ++++
 rtl/el2_iccm_ecc_gen.sv | 31 +++
 rtl/el2_ifu_iccm_access_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_el2_ifu_iccm_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared types for the ICCM access controller: FSM states, size encodings and
// the ECC-protected ICCM write payload.
package el2_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ECC_W  = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      RMW_RD  = 3'd3,
      RMW_WR  = 3'd4,
      WR      = 3'd5,
      CORR_WR = 3'd6,
      RSP     = 3'd7
   } iccm_state_e;

   localparam logic [2:0] WR_SIZE_WORD  = 3'b010;
   localparam logic [2:0] WR_SIZE_DWORD = 3'b011;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef struct packed {
      logic [ECC_W-1:0]  ecc1;
      logic [DATA_W-1:0] data1;
      logic [ECC_W-1:0]  ecc0;
      logic [DATA_W-1:0] data0;
   } iccm_wr_data_t;

   // Address is misaligned when any bit below the access size is set.
   function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = |lo[1:0];
         default: mis = |lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/el2_iccm_ecc_gen.sv
// 32-bit SECDED encoder: six Hamming check bits over codeword positions 1..38
// (checks at powers of two) plus an overall parity bit.
module el2_iccm_ecc_gen
   import el2_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [ECC_W-1:0]  ecc_o
);

   logic [5:0] hamming_c;

   // Walk codeword positions, skipping check-bit slots, and fold each data bit
   // into every check bit whose index is set in its position.
   always_comb begin
      logic [4:0] didx;
      logic [5:0] pb;
      hamming_c = '0;
      didx      = '0;
      pb        = '0;
      for (int pos = 1; pos <= 38; pos++) begin
         pb = 6'(pos);
         if ((pb & (pb - 6'd1)) != 6'd0) begin
            hamming_c = hamming_c ^ ({6{data_i[didx]}} & pb);
            didx      = didx + 5'd1;
         end
      end
   end

   assign ecc_o = {^{data_i, hamming_c}, hamming_c};

endmodule

// File: rtl/el2_ifu_iccm_access_ctrl.sv
// ICCM access controller: serialises read/write requests onto the ICCM port,
// handles sub-word writes by read-modify-write and scrubs single-bit ECC errors.
module el2_ifu_iccm_access_ctrl
   import el2_pkg::*;
#(
   parameter int unsigned ICCM_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ICCM_BITS-1:0] req_addr,
   input  logic [1:0]           req_size,
   input  logic [63:0]          req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [63:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic                 iccm_rden,
   output logic                 iccm_wren,
   output logic [ICCM_BITS-1:1] iccm_rw_addr,
   output logic [2:0]           iccm_wr_size,
   output logic [77:0]          iccm_wr_data,
   output logic                 iccm_buf_correct_ecc,
   output logic                 iccm_correction_state,
   input  logic [63:0]          iccm_rd_data,
   input  logic                 iccm_rd_ecc_single_err,
   input  logic                 iccm_rd_ecc_double_err
);

   iccm_state_e state_q, state_d;
   logic        phase_q, phase_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic [15:0] wdata_q, wdata_d;

   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [63:0]          rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 rden_q, rden_d;
   logic                 wren_q, wren_d;
   logic [ICCM_BITS-1:1] rw_addr_q, rw_addr_d;
   logic [2:0]           wr_size_q, wr_size_d;
   iccm_wr_data_t        wr_data_q, wr_data_d;
   logic                 buf_corr_q, buf_corr_d;
   logic                 corr_state_q, corr_state_d;

   logic [31:0]      merged_c;
   logic [63:0]      wr_src_c;
   logic [ECC_W-1:0] ecc0_c, ecc1_c;
   iccm_wr_data_t    wr_enc_c;

   // Write payload source; the addressed word of a word-aligned read returns in bits [31:0].
   always_comb begin
      merged_c = iccm_rd_data[31:0];
      if (size_q == SZ_BYTE) begin
         merged_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged_c[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
      case (state_q)
         RD_WAIT: wr_src_c = iccm_rd_data;
         RMW_RD:  wr_src_c = {2{merged_c}};
         default: wr_src_c = (req_size == SZ_DWORD) ? req_wdata : {2{req_wdata[31:0]}};
      endcase
   end

   el2_iccm_ecc_gen u_ecc_lo (.data_i(wr_src_c[31:0]),  .ecc_o(ecc0_c));
   el2_iccm_ecc_gen u_ecc_hi (.data_i(wr_src_c[63:32]), .ecc_o(ecc1_c));

   assign wr_enc_c = {ecc1_c, wr_src_c[63:32], ecc0_c, wr_src_c[31:0]};

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      off_d        = off_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      req_ready_d  = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      rden_d       = 1'b0;
      wren_d       = 1'b0;
      buf_corr_d   = 1'b0;
      corr_state_d = 1'b0;
      rw_addr_d    = rw_addr_q;
      wr_size_d    = wr_size_q;
      wr_data_d    = wr_data_q;

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               off_d       = req_addr[1:0];
               size_d      = req_size;
               wdata_d     = req_wdata[15:0];
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               rw_addr_d   = req_addr[ICCM_BITS-1:1];
               if (is_misaligned(req_addr[2:0], req_size)) begin
                  state_d     = RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (!req_write) begin
                  state_d = RD;
                  rden_d  = 1'b1;
               end else if (req_size == SZ_WORD || req_size == SZ_DWORD) begin
                  state_d   = WR;
                  wren_d    = 1'b1;
                  wr_size_d = (req_size == SZ_DWORD) ? WR_SIZE_DWORD : WR_SIZE_WORD;
                  wr_data_d = wr_enc_c;
               end else begin
                  state_d   = RMW_RD;
                  phase_d   = 1'b0;
                  rden_d    = 1'b1;
                  rw_addr_d = {req_addr[ICCM_BITS-1:2], 1'b0};
               end
            end
         end
         RD: state_d = RD_WAIT;
         RD_WAIT: begin
            if (iccm_rd_ecc_double_err) begin
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else if (iccm_rd_ecc_single_err) begin
               state_d      = CORR_WR;
               rsp_rdata_d  = iccm_rd_data;
               wren_d       = 1'b1;
               buf_corr_d   = 1'b1;
               corr_state_d = 1'b1;
               wr_size_d    = WR_SIZE_DWORD;
               wr_data_d    = wr_enc_c;
            end else begin
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = iccm_rd_data;
            end
         end
         // Phase 0 drives the read strobe, phase 1 samples and merges.
         RMW_RD: begin
            phase_d = 1'b1;
            if (phase_q) begin
               phase_d = 1'b0;
               if (iccm_rd_ecc_double_err) begin
                  state_d     = RSP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d   = RMW_WR;
                  wren_d    = 1'b1;
                  wr_size_d = WR_SIZE_WORD;
                  wr_data_d = wr_enc_c;
               end
            end
         end
         RMW_WR, WR, CORR_WR: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
         end
         RSP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = '0;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         phase_q      <= 1'b0;
         off_q        <= '0;
         size_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         rden_q       <= 1'b0;
         wren_q       <= 1'b0;
         rw_addr_q    <= '0;
         wr_size_q    <= '0;
         wr_data_q    <= '0;
         buf_corr_q   <= 1'b0;
         corr_state_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         off_q        <= off_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         rden_q       <= rden_d;
         wren_q       <= wren_d;
         rw_addr_q    <= rw_addr_d;
         wr_size_q    <= wr_size_d;
         wr_data_q    <= wr_data_d;
         buf_corr_q   <= buf_corr_d;
         corr_state_q <= corr_state_d;
      end
   end

   assign req_ready             = req_ready_q;
   assign rsp_valid             = rsp_valid_q;
   assign rsp_rdata             = rsp_rdata_q;
   assign rsp_err               = rsp_err_q;
   assign iccm_rden             = rden_q;
   assign iccm_wren             = wren_q;
   assign iccm_rw_addr          = rw_addr_q;
   assign iccm_wr_size          = wr_size_q;
   assign iccm_wr_data          = wr_data_q;
   assign iccm_buf_correct_ecc  = buf_corr_q;
   assign iccm_correction_state = corr_state_q;

endmodule

// File: tb/tb_el2_ifu_iccm_access_ctrl.sv
// Directed bench for the ICCM access controller: reads, ECC scrub, writes,
// read-modify-write, misalignment and reset behaviour.
module tb_el2_ifu_iccm_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        iccm_rden, iccm_wren;
   logic [15:1] iccm_rw_addr;
   logic [2:0]  iccm_wr_size;
   logic [77:0] iccm_wr_data;
   logic        iccm_buf_correct_ecc, iccm_correction_state;
   logic [63:0] iccm_rd_data = '0;
   logic        iccm_rd_ecc_single_err = 1'b0;
   logic        iccm_rd_ecc_double_err = 1'b0;

   int checks = 0;
   int passed = 0;
   int rden_cnt = 0, wren_cnt = 0, rspv_cnt = 0, both_cnt = 0;
   logic [77:0] exp78;

   el2_ifu_iccm_access_ctrl #(.ICCM_BITS(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .iccm_rden(iccm_rden), .iccm_wren(iccm_wren), .iccm_rw_addr(iccm_rw_addr),
      .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
      .iccm_buf_correct_ecc(iccm_buf_correct_ecc), .iccm_correction_state(iccm_correction_state),
      .iccm_rd_data(iccm_rd_data), .iccm_rd_ecc_single_err(iccm_rd_ecc_single_err),
      .iccm_rd_ecc_double_err(iccm_rd_ecc_double_err)
   );

   always #5 clk = ~clk;

   // Strobe activity of each completed cycle.
   always @(posedge clk) begin
      if (iccm_rden) rden_cnt++;
      if (iccm_wren) wren_cnt++;
      if (rsp_valid) rspv_cnt++;
      if (iccm_rden && iccm_wren) both_cnt++;
   end

   // Reference SECDED: data bit i sits at the i-th non-power-of-two codeword position.
   function automatic logic [6:0] ecc_model(input logic [31:0] d);
      logic [5:0] h;
      int p;
      h = '0;
      for (int i = 0; i < 32; i++) begin
         p = i + 1;
         for (int j = 0; j < 6; j++) if ((1 << j) <= p) p++;
         for (int k = 0; k < 6; k++) if (((p >> k) & 1) == 1 && d[i]) h[k] = ~h[k];
      end
      return {^{d, h}, h};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [1:0] sz, input logic [63:0] wd);
      req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic clear_counts();
      rden_cnt = 0; wren_cnt = 0; rspv_cnt = 0;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b want 0", req_ready); else passed++;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); else passed++;
      checks++; if ({iccm_rden, iccm_wren, iccm_buf_correct_ecc, iccm_correction_state} !== 4'b0) $display("FAIL rst_strobes: got %b want 0000", {iccm_rden, iccm_wren, iccm_buf_correct_ecc, iccm_correction_state}); else passed++;
      checks++; if (iccm_wr_data !== 78'h0) $display("FAIL rst_wr_data: got %h want 0", iccm_wr_data); else passed++;
      rst = 1'b0;
      step();
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", req_ready); else passed++;
   endtask

   task automatic test_read_dword();
      clear_counts();
      issue(1'b0, 16'h0010, 2'd3, 64'h0);
      checks++; if (iccm_rden !== 1'b1) $display("FAIL rd_rden: got %0b want 1", iccm_rden); else passed++;
      checks++; if (iccm_rw_addr !== 15'h0008) $display("FAIL rd_addr: got %h want 0008", iccm_rw_addr); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL rd_busy_ready: got %0b want 0", req_ready); else passed++;
      step();
      iccm_rd_data = 64'hDEAD_BEEF_0123_4567;
      checks++; if ({rsp_valid, iccm_rden} !== 2'b00) $display("FAIL rd_wait: got %b want 00", {rsp_valid, iccm_rden}); else passed++;
      step();
      iccm_rd_data = 64'h0;
      checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %0b want 1", rsp_valid); else passed++;
      checks++; if (rsp_rdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL rd_rdata: got %h want deadbeef01234567", rsp_rdata); else passed++;
      checks++; if (rsp_err !== 1'b0) $display("FAIL rd_err: got %0b want 0", rsp_err); else passed++;
      step();
      checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 64'hDEAD_BEEF_0123_4567}) $display("FAIL rd_hold: got %b/%h want 1/deadbeef01234567", rsp_valid, rsp_rdata); else passed++;
      handshake();
      checks++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL rd_done: got %b want 01", {rsp_valid, req_ready}); else passed++;
      checks++; if (rden_cnt !== 1 || wren_cnt !== 0) $display("FAIL rd_strobe_cnt: got %0d/%0d want 1/0", rden_cnt, wren_cnt); else passed++;
   endtask

   task automatic test_read_single_err();
      clear_counts();
      issue(1'b0, 16'h0010, 2'd3, 64'h0);
      step();
      iccm_rd_data = 64'h0123_4567_89AB_CDEF;
      iccm_rd_ecc_single_err = 1'b1;
      step();
      iccm_rd_ecc_single_err = 1'b0;
      exp78 = {ecc_model(32'h0123_4567), 32'h0123_4567, ecc_model(32'h89AB_CDEF), 32'h89AB_CDEF};
      checks++; if ({iccm_wren, iccm_buf_correct_ecc, iccm_correction_state, iccm_rden} !== 4'b1110) $display("FAIL corr_strobes: got %b want 1110", {iccm_wren, iccm_buf_correct_ecc, iccm_correction_state, iccm_rden}); else passed++;
      checks++; if (iccm_rw_addr !== 15'h0008) $display("FAIL corr_addr: got %h want 0008", iccm_rw_addr); else passed++;
      checks++; if (iccm_wr_size !== 3'b011) $display("FAIL corr_size: got %b want 011", iccm_wr_size); else passed++;
      checks++; if (iccm_wr_data !== exp78) $display("FAIL corr_wr_data: got %h want %h", iccm_wr_data, exp78); else passed++;
      checks++; if (rsp_valid !== 1'b0) $display("FAIL corr_early_rsp: got %0b want 0", rsp_valid); else passed++;
      step();
      checks++; if ({rsp_valid, rsp_err, iccm_wren, iccm_buf_correct_ecc} !== 4'b1000) $display("FAIL corr_rsp: got %b want 1000", {rsp_valid, rsp_err, iccm_wren, iccm_buf_correct_ecc}); else passed++;
      checks++; if (rsp_rdata !== 64'h0123_4567_89AB_CDEF) $display("FAIL corr_rdata: got %h want 0123456789abcdef", rsp_rdata); else passed++;
      handshake();
      checks++; if (rden_cnt !== 1 || wren_cnt !== 1) $display("FAIL corr_strobe_cnt: got %0d/%0d want 1/1", rden_cnt, wren_cnt); else passed++;
   endtask

   task automatic test_read_double_err();
      clear_counts();
      issue(1'b0, 16'h0018, 2'd2, 64'h0);
      step();
      iccm_rd_data = 64'h5555_5555_AAAA_AAAA;
      iccm_rd_ecc_single_err = 1'b1;
      iccm_rd_ecc_double_err = 1'b1;
      step();
      iccm_rd_ecc_single_err = 1'b0;
      iccm_rd_ecc_double_err = 1'b0;
      checks++; if ({rsp_valid, rsp_err, iccm_wren} !== 3'b110) $display("FAIL dbl_rsp: got %b want 110", {rsp_valid, rsp_err, iccm_wren}); else passed++;
      checks++; if (rsp_rdata !== 64'h0) $display("FAIL dbl_rdata: got %h want 0", rsp_rdata); else passed++;
      handshake();
      checks++; if (wren_cnt !== 0) $display("FAIL dbl_wren_cnt: got %0d want 0", wren_cnt); else passed++;
   endtask

   task automatic test_write_word();
      clear_counts();
      issue(1'b1, 16'h0024, 2'd2, 64'hFFFF_0000_1234_5678);
      exp78 = {ecc_model(32'h1234_5678), 32'h1234_5678, ecc_model(32'h1234_5678), 32'h1234_5678};
      checks++; if ({iccm_wren, iccm_rden} !== 2'b10) $display("FAIL ww_strobes: got %b want 10", {iccm_wren, iccm_rden}); else passed++;
      checks++; if (iccm_wr_size !== 3'b010 || iccm_rw_addr !== 15'h0012) $display("FAIL ww_size_addr: got %b/%h want 010/0012", iccm_wr_size, iccm_rw_addr); else passed++;
      checks++; if (iccm_wr_data !== exp78) $display("FAIL ww_wr_data: got %h want %h", iccm_wr_data, exp78); else passed++;
      step();
      checks++; if ({rsp_valid, rsp_err, iccm_wren} !== 3'b100 || rsp_rdata !== 64'h0) $display("FAIL ww_rsp: got %b/%h want 100/0", {rsp_valid, rsp_err, iccm_wren}, rsp_rdata); else passed++;
      handshake();
   endtask

   task automatic test_write_dword();
      issue(1'b1, 16'h0028, 2'd3, 64'hCAFE_F00D_5555_AAAA);
      exp78 = {ecc_model(32'hCAFE_F00D), 32'hCAFE_F00D, ecc_model(32'h5555_AAAA), 32'h5555_AAAA};
      checks++; if (iccm_wr_size !== 3'b011 || iccm_rw_addr !== 15'h0014) $display("FAIL wd_size_addr: got %b/%h want 011/0014", iccm_wr_size, iccm_rw_addr); else passed++;
      checks++; if (iccm_wr_data !== exp78) $display("FAIL wd_wr_data: got %h want %h", iccm_wr_data, exp78); else passed++;
      step();
      checks++; if (rsp_valid !== 1'b1) $display("FAIL wd_rsp_valid: got %0b want 1", rsp_valid); else passed++;
      handshake();
   endtask

   task automatic test_rmw_byte();
      clear_counts();
      issue(1'b1, 16'h0013, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB);
      checks++; if ({iccm_rden, iccm_wren} !== 2'b10 || iccm_rw_addr !== 15'h0008) $display("FAIL rmwb_rd: got %b/%h want 10/0008", {iccm_rden, iccm_wren}, iccm_rw_addr); else passed++;
      step();
      iccm_rd_data = {32'h9988_7766, 32'h1122_3344};
      checks++; if ({iccm_rden, iccm_wren} !== 2'b00) $display("FAIL rmwb_wait: got %b want 00", {iccm_rden, iccm_wren}); else passed++;
      step();
      exp78 = {ecc_model(32'hAB22_3344), 32'hAB22_3344, ecc_model(32'hAB22_3344), 32'hAB22_3344};
      checks++; if ({iccm_wren, iccm_rden, rsp_valid} !== 3'b100) $display("FAIL rmwb_wr: got %b want 100", {iccm_wren, iccm_rden, rsp_valid}); else passed++;
      checks++; if (iccm_wr_size !== 3'b010 || iccm_rw_addr !== 15'h0008) $display("FAIL rmwb_size_addr: got %b/%h want 010/0008", iccm_wr_size, iccm_rw_addr); else passed++;
      checks++; if (iccm_wr_data !== exp78) $display("FAIL rmwb_wr_data: got %h want %h", iccm_wr_data, exp78); else passed++;
      step();
      checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL rmwb_rsp: got %b want 10", {rsp_valid, rsp_err}); else passed++;
      handshake();
      checks++; if (rden_cnt !== 1 || wren_cnt !== 1) $display("FAIL rmwb_strobe_cnt: got %0d/%0d want 1/1", rden_cnt, wren_cnt); else passed++;
   endtask

   task automatic test_rmw_half();
      issue(1'b1, 16'h0016, 2'd1, 64'h0000_0000_0000_5A5A);
      checks++; if (iccm_rw_addr !== 15'h000A) $display("FAIL rmwh_addr: got %h want 000a", iccm_rw_addr); else passed++;
      step();
      iccm_rd_data = {32'h0, 32'h1122_3344};
      step();
      exp78 = {ecc_model(32'h5A5A_3344), 32'h5A5A_3344, ecc_model(32'h5A5A_3344), 32'h5A5A_3344};
      checks++; if (iccm_wr_data !== exp78) $display("FAIL rmwh_wr_data: got %h want %h", iccm_wr_data, exp78); else passed++;
      step();
      checks++; if (rsp_valid !== 1'b1) $display("FAIL rmwh_rsp_valid: got %0b want 1", rsp_valid); else passed++;
      handshake();
   endtask

   task automatic test_misaligned();
      clear_counts();
      issue(1'b1, 16'h0001, 2'd1, 64'h1234);
      checks++; if ({rsp_valid, rsp_err, iccm_rden, iccm_wren} !== 4'b1100) $display("FAIL mis_rsp: got %b want 1100", {rsp_valid, rsp_err, iccm_rden, iccm_wren}); else passed++;
      handshake();
      checks++; if (rden_cnt !== 0 || wren_cnt !== 0) $display("FAIL mis_strobe_cnt: got %0d/%0d want 0/0", rden_cnt, wren_cnt); else passed++;
   endtask

   task automatic test_rmw_double_err();
      clear_counts();
      issue(1'b1, 16'h0021, 2'd0, 64'hCD);
      step();
      iccm_rd_data = {32'h0, 32'hFFFF_FFFF};
      iccm_rd_ecc_double_err = 1'b1;
      step();
      iccm_rd_ecc_double_err = 1'b0;
      checks++; if ({rsp_valid, rsp_err, iccm_wren} !== 3'b110) $display("FAIL rmwd_rsp: got %b want 110", {rsp_valid, rsp_err, iccm_wren}); else passed++;
      handshake();
      checks++; if (wren_cnt !== 0) $display("FAIL rmwd_wren_cnt: got %0d want 0", wren_cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 16'h0010, 2'd3, 64'h0);
      step();
      iccm_rd_data = 64'h1111_2222_3333_4444;
      iccm_rd_ecc_single_err = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if ({req_ready, rsp_valid, rsp_err, iccm_rden, iccm_wren, iccm_buf_correct_ecc, iccm_correction_state} !== 7'b0) $display("FAIL rmid_flags: got %b want 0000000", {req_ready, rsp_valid, rsp_err, iccm_rden, iccm_wren, iccm_buf_correct_ecc, iccm_correction_state}); else passed++;
      checks++; if (iccm_rw_addr !== 15'h0 || iccm_wr_size !== 3'b0) $display("FAIL rmid_addr_size: got %h/%b want 0/000", iccm_rw_addr, iccm_wr_size); else passed++;
      checks++; if (iccm_wr_data !== 78'h0 || rsp_rdata !== 64'h0) $display("FAIL rmid_data: got %h/%h want 0/0", iccm_wr_data, rsp_rdata); else passed++;
      clear_counts();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      iccm_rd_ecc_single_err = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (rspv_cnt !== 0 || rden_cnt !== 0 || wren_cnt !== 0) $display("FAIL rmid_after: got rsp %0d rden %0d wren %0d want 0/0/0", rspv_cnt, rden_cnt, wren_cnt); else passed++;
      checks++; if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %0b want 1", req_ready); else passed++;
   endtask

   initial begin
      test_reset();
      test_read_dword();
      test_read_single_err();
      test_read_double_err();
      test_write_word();
      test_write_dword();
      test_rmw_byte();
      test_rmw_half();
      test_misaligned();
      test_rmw_double_err();
      test_reset_mid();
      checks++; if (both_cnt !== 0) $display("FAIL rden_wren_overlap: got %0d cycles want 0", both_cnt); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
